// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encodings and add/sub mode constants.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_operator.sv
// Combinational one-bit full adder/subtractor cell shared by the serial datapath.
module full_operator
  import arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  logic w_diff;

  assign w_diff = x ^ y;
  assign s      = w_diff ^ cin;

  // In subtract mode cout is a borrow: set when x - y - cin goes negative.
  assign cout = (mode == MODE_SUB) ? ((~x & y) | (cin & ~w_diff))
                                   : ((x & y)  | (cin & w_diff));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Optional signed overflow output enabled by defining ADDSUB_OVF_EN.
module serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow
`ifdef ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  // state   | meaning
  // IDLE    | waiting for operands, in_ready=1
  // RUN     | one operand bit processed per cycle
  // DONE    | result held, out_valid=1 until out_ready

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_mode;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  full_operator u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_c),
    .mode (r_mode),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_mode <= MODE_ADD;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_mode <= mode;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_res  <= {w_s, r_res[WIDTH-1:1]};
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_c    <= w_cout;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign result       = r_res;
  assign carry_borrow = r_c;

`ifdef ADDSUB_OVF_EN
  logic r_ovf;

  // On the final RUN edge the operand LSBs are the original MSBs and w_s is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      if (r_mode == MODE_SUB) begin
        r_ovf <= (r_a[0] != r_b[0]) && (w_s != r_a[0]);
      end else begin
        r_ovf <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
      end
    end
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;
  localparam int PERIOD = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_borrow;
`ifdef ADDSUB_OVF_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         cb;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  time  t_accept;

  always #(PERIOD/2) clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .carry_borrow (carry_borrow)
`ifdef ADDSUB_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic exp_t model(input int ua, input int ub, input logic m);
    exp_t e;
    int sa, sb, sr, ur;
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (m) begin
      ur = ua - ub;
      sr = sa - sb;
      e.cb = (ua < ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      e.cb = (ur >= (1 << W));
    end
    e.r  = W'(ur & ((1 << W) - 1));
    e.ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return e;
  endfunction

  // Continuous compare against the queued expectation while a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (out_valid) begin
      chk("in_ready_low_in_done", in_ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("result", result, exp_q[0].r);
        chk("carry_borrow", carry_borrow, exp_q[0].cb);
`ifdef ADDSUB_OVF_EN
        chk("overflow", overflow, exp_q[0].ov);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic accept(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic m_i);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_wait_timeout", in_ready, 1);
    a = a_i; b = b_i; mode = m_i; in_valid = 1'b1;
    @(posedge clk);
    t_accept = $time;
    exp_q.push_back(model(int'(a_i), int'(b_i), m_i));
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic m_i,
                       input int hold, input bit lit, input logic [W-1:0] r_lit,
                       input logic cb_lit, input logic ov_lit);
    int lat;
    accept(a_i, b_i, m_i);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, W);
    if (lit) begin
      chk("lit_result", result, r_lit);
      chk("lit_carry_borrow", carry_borrow, cb_lit);
`ifdef ADDSUB_OVF_EN
      chk("lit_overflow", overflow, ov_lit);
`else
      if (ov_lit === 1'bx) chk("lit_overflow_unused", 0, 1);
`endif
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t1;
    #3;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_carry_borrow", carry_borrow, 0);
`ifdef ADDSUB_OVF_EN
    chk("reset_overflow", overflow, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset_in_ready", in_ready, 1);

    issue(8'd200, 8'd100, 1'b0, 0, 1'b1, 8'd44,  1'b1, 1'b0);
    issue(8'd100, 8'd100, 1'b0, 0, 1'b1, 8'd200, 1'b0, 1'b1);
    issue(8'd5,   8'd9,   1'b1, 0, 1'b1, 8'd252, 1'b1, 1'b0);
    issue(8'h80,  8'h01,  1'b1, 0, 1'b1, 8'h7F,  1'b0, 1'b1);

    // Backpressure then back-to-back issue interval.
    issue(8'd77, 8'd13, 1'b1, 3, 1'b0, '0, 1'b0, 1'b0);
    issue(8'd33, 8'd44, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
    t1 = t_accept;
    issue(8'd250, 8'd6, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
    chk("issue_interval", longint'((t_accept - t1) / PERIOD), 10);

    // Reset mid-RUN, at bit 4.
    accept(8'hAB, 8'h5C, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_result", result, 0);
    chk("midrun_rst_carry_borrow", carry_borrow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("after_rst_out_valid", out_valid, 0);
    issue(8'd1, 8'd1, 1'b0, 0, 1'b1, 8'd2, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic         rm;
      ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) begin ra = '0; rb = '1; end
      issue(ra, rb, rm, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
